// File: rtl/dcache_refill_engine.sv
// -----------------------------------------------------------------------------
// dcache_refill_engine
//
// Purpose: on a data-cache miss, fetches the whole cache line from memory
// (one line request, then 2^WORD_BITS data beats in word order) and writes
// each beat into the data RAM as it arrives. A one-cycle refill_done pulse
// reports the refilled line. A saturating counter tracks completed refills.
//
// Handshakes: a transfer on miss_* or mem_req_* happens on a rising edge
// where valid and ready are both high. The engine holds mem_req_valid and
// mem_req_addr stable until mem_req_ready is seen. Memory responses have no
// backpressure: every cycle with mem_resp_valid=1 during FILL is one beat.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   miss_valid/ready  miss request handshake, miss_addr = byte address
//   mem_req_valid/ready, mem_req_addr   line read request to memory
//   mem_resp_valid, mem_resp_data       incoming data beats
//   ram_addr, ram_d, ram_we             data RAM write port
//   refill_done, refill_line            end-of-refill pulse and its line
//   busy              high whenever the engine is not idle
//   refill_count      completed refills, saturating at 0xFFFF
//   dbg_state_o       current FSM state (0=IDLE 1=REQ 2=FILL 3=DONE)
//
// While rst is high every output is forced low.
// -----------------------------------------------------------------------------
module dcache_refill_engine #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 8,
  parameter int WORD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [31:0]       miss_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DWIDTH-1:0] mem_resp_data,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  output logic              ram_we,
  output logic              refill_done,
  output logic [31:0]       refill_line,
  output logic              busy,
  output logic [15:0]       refill_count,
  output logic [1:0]        dbg_state_o
);

  // Byte-offset bits within a line: word index plus 2 bits of byte offset.
  localparam int OFF_BITS = WORD_BITS + 2;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [WORD_BITS-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          line_addr_q, line_addr_d;
  logic [WORD_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]          refill_count_q, refill_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      line_addr_q    <= '0;
      beat_cnt_q     <= '0;
      refill_count_q <= '0;
    end else begin
      state_q        <= state_d;
      line_addr_q    <= line_addr_d;
      beat_cnt_q     <= beat_cnt_d;
      refill_count_q <= refill_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    line_addr_d    = line_addr_q;
    beat_cnt_d     = beat_cnt_q;
    refill_count_d = refill_count_q;
    miss_ready     = 1'b0;
    mem_req_valid  = 1'b0;
    ram_we         = 1'b0;
    refill_done    = 1'b0;
    busy           = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        miss_ready = 1'b1;
        if (miss_valid) begin
          line_addr_d = miss_addr & LINE_MASK;
          beat_cnt_d  = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // Beats are written straight through to the RAM in the cycle they
        // arrive; the counter wraps back to 0 on the last beat.
        if (mem_resp_valid) begin
          ram_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        refill_done = 1'b1;
        if (refill_count_q != 16'hFFFF) begin
          refill_count_d = refill_count_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset overrides every control output immediately, before the
    // synchronous reset has taken effect on the state register.
    if (rst) begin
      miss_ready    = 1'b0;
      mem_req_valid = 1'b0;
      ram_we        = 1'b0;
      refill_done   = 1'b0;
      busy          = 1'b0;
    end
  end

  assign mem_req_addr = rst ? '0 : line_addr_q;
  assign ram_addr     = rst ? '0 : {line_addr_q[AWIDTH+1:OFF_BITS], beat_cnt_q};
  assign ram_d        = rst ? '0 : mem_resp_data;
  assign refill_line  = rst ? '0 : line_addr_q;
  assign refill_count = rst ? '0 : refill_count_q;
  assign dbg_state_o  = rst ? 2'd0 : state_q;

endmodule

// File: tb/tb_dcache_refill_engine.sv
// -----------------------------------------------------------------------------
// tb_dcache_refill_engine
//
// Self-checking bench for dcache_refill_engine (DWIDTH=32, AWIDTH=8,
// WORD_BITS=2). Inputs are driven 2 time units after the rising edge,
// control outputs are read 3 units after it, and RAM writes / done pulses are
// collected on the falling edge. Expected RAM writes come from a line/word
// address model and sit in exp_q; each observed write must match the head.
// -----------------------------------------------------------------------------
module tb_dcache_refill_engine;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int WB = 2;
  localparam int NB = 1 << WB;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_valid;
  logic          miss_ready;
  logic [31:0]   miss_addr;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic          refill_done;
  logic [31:0]   refill_line;
  logic          busy;
  logic [15:0]   refill_count;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int model_count = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [31:0]      done_line_q[$];
  int               done_cyc_q[$];

  dcache_refill_engine #(.DWIDTH(DW), .AWIDTH(AW), .WORD_BITS(WB)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we),
    .refill_done(refill_done), .refill_line(refill_line),
    .busy(busy), .refill_count(refill_count), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter / watchdog ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model helpers ----------------
  // RAM word index: line number times words-per-line plus beat, modulo RAM depth.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a, input int beat);
    int unsigned w;
    w = (a / (4 * NB)) * NB + beat;
    return w[AW-1:0];
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return (a / (4 * NB)) * (4 * NB);
  endfunction

  // ---------------- scoreboard: RAM writes and done pulses ----------------
  initial forever begin
    logic [AW+DW-1:0] e;
    @(negedge clk);
    if (ram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ram_write unexpected got addr=%h data=%h exp none", ram_addr, ram_d);
      end else begin
        e = exp_q.pop_front();
        if ({ram_addr, ram_d} !== e) begin
          failures++;
          $display("FAIL ram_write got addr=%h data=%h exp addr=%h data=%h",
                   ram_addr, ram_d, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (refill_done === 1'b1) begin
      done_line_q.push_back(refill_line);
      done_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    miss_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    model_count = 0;
    done_line_q.delete();
    done_cyc_q.delete();
  endtask

  // Runs one complete refill: miss, stall cycles of request backpressure,
  // gap idle cycles before each beat. Returns the acceptance cycle, the
  // number of request cycles whose valid/addr were wrong, and the last
  // request address seen. Returns in the cycle refill_done is high (or on
  // timeout, which the caller notices as a missing done pulse).
  task automatic do_refill(input logic [31:0] addr, input int stall, input int gap,
                           input bit spurious, input bit fixed, input logic [DW-1:0] base,
                           output int acc, output int rerr, output logic [31:0] ra);
    logic [31:0]   line;
    logic [DW-1:0] d;
    int            guard;
    line = line_of(addr);
    rerr = 0;
    ra   = '0;
    @(posedge clk); #2;
    miss_valid = 1'b1; miss_addr = addr; mem_req_ready = 1'b0;
    mem_resp_valid = spurious; mem_resp_data = $urandom;
    #1;
    guard = 0;
    while (miss_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #3;
      guard++;
    end
    acc = cyc;
    @(posedge clk); #2;
    miss_valid = 1'b0; miss_addr = $urandom;
    for (int s = 0; s <= stall; s++) begin
      mem_req_ready = (s == stall);
      mem_resp_valid = spurious; mem_resp_data = $urandom;
      #1;
      ra = mem_req_addr;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== line) rerr++;
      @(posedge clk); #2;
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < NB; i++) begin
      for (int g = 0; g < gap; g++) begin
        mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        @(posedge clk); #2;
      end
      d = fixed ? base + DW'(i) : DW'($urandom);
      mem_resp_valid = 1'b1; mem_resp_data = d;
      exp_q.push_back({word_idx(addr, i), d});
      @(posedge clk); #2;
    end
    mem_resp_valid = spurious; mem_resp_data = $urandom;
    #1;
    guard = 0;
    while (refill_done !== 1'b1 && guard < 40) begin
      @(posedge clk); #3;
      guard++;
    end
    mem_resp_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    miss_valid = 1'b1; miss_addr = 32'h0000_1234;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if ({miss_ready, mem_req_valid, ram_we, refill_done, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got rdy=%b req=%b we=%b done=%b busy=%b exp all 0",
               miss_ready, mem_req_valid, ram_we, refill_done, busy);
    end
    checks++;
    if (refill_count !== 16'd0 || mem_req_addr !== 32'd0 || refill_line !== 32'd0 ||
        ram_addr !== '0 || ram_d !== '0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_data got cnt=%h req_addr=%h line=%h ram_addr=%h ram_d=%h st=%0d exp 0",
               refill_count, mem_req_addr, refill_line, ram_addr, ram_d, dbg_state);
    end
    @(posedge clk); #2;
    rst = 1'b0; miss_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (miss_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got miss_ready=%b busy=%b exp 1 0", miss_ready, busy);
    end
    model_count = 0;
  endtask

  task automatic test_basic();
    int acc, rerr, dc;
    logic [31:0] ra, line;
    do_refill(32'h0000_1234, 0, 0, 1'b0, 1'b1, 32'hA0, acc, rerr, ra);
    @(posedge clk); #3;
    model_count = (model_count + 1 > 65535) ? 65535 : model_count + 1;
    checks++;
    if (ra !== 32'h0000_1230 || rerr != 0) begin
      failures++;
      $display("FAIL basic_req_addr got %h errs=%0d exp 00001230 errs=0", ra, rerr);
    end
    checks++;
    if (done_line_q.size() != 1) begin
      failures++;
      $display("FAIL basic_done_pulses got %0d exp 1", done_line_q.size());
    end else begin
      line = done_line_q.pop_front();
      dc = done_cyc_q.pop_front();
      checks++;
      if (line !== 32'h0000_1230) begin
        failures++;
        $display("FAIL basic_refill_line got %h exp 00001230", line);
      end
      checks++;
      if (dc - acc + 1 != 7) begin
        failures++;
        $display("FAIL basic_latency got %0d exp 7", dc - acc + 1);
      end
    end
    checks++;
    if (exp_q.size() != 0 || refill_count !== 16'(model_count)) begin
      failures++;
      $display("FAIL basic_count got cnt=%0d missing=%0d exp cnt=%0d missing=0",
               refill_count, exp_q.size(), model_count);
    end
  endtask

  task automatic test_stall();
    int acc, rerr, dc;
    logic [31:0] ra, addr;
    addr = $urandom;
    do_refill(addr, 5, 1, 1'b0, 1'b0, '0, acc, rerr, ra);
    @(posedge clk); #3;
    model_count = (model_count + 1 > 65535) ? 65535 : model_count + 1;
    checks++;
    if (rerr != 0) begin
      failures++;
      $display("FAIL stall_req_stable got %0d bad request cycles exp 0", rerr);
    end
    checks++;
    if (done_line_q.size() != 1) begin
      failures++;
      $display("FAIL stall_done_pulses got %0d exp 1", done_line_q.size());
    end else begin
      void'(done_line_q.pop_front());
      dc = done_cyc_q.pop_front();
      checks++;
      if (dc - acc + 1 != 3 + 5 + NB * 2) begin
        failures++;
        $display("FAIL stall_latency got %0d exp %0d", dc - acc + 1, 3 + 5 + NB * 2);
      end
    end
    checks++;
    if (exp_q.size() != 0 || refill_count !== 16'(model_count)) begin
      failures++;
      $display("FAIL stall_count got cnt=%0d missing=%0d exp cnt=%0d missing=0",
               refill_count, exp_q.size(), model_count);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, rerr1, rerr2, dc1, dc2;
    logic [31:0] ra, l1, l2;
    apply_reset();
    do_refill(32'h0000_0000, 0, 0, 1'b0, 1'b0, '0, acc1, rerr1, ra);
    // Present the next miss already during DONE; it must wait one cycle.
    miss_valid = 1'b1; miss_addr = 32'h0000_03F0;
    checks++;
    if (miss_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_in_done got %b exp 0", miss_ready);
    end
    do_refill(32'h0000_03F0, 0, 0, 1'b0, 1'b0, '0, acc2, rerr2, ra);
    @(posedge clk); #3;
    model_count = 2;
    checks++;
    if (done_line_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_done_pulses got %0d exp 2", done_line_q.size());
    end else begin
      l1 = done_line_q.pop_front(); dc1 = done_cyc_q.pop_front();
      l2 = done_line_q.pop_front(); dc2 = done_cyc_q.pop_front();
      checks++;
      if (l1 !== 32'h0 || l2 !== 32'h0000_03F0) begin
        failures++;
        $display("FAIL b2b_lines got %h %h exp 00000000 000003f0", l1, l2);
      end
      checks++;
      if (acc2 != dc1 + 1 || dc2 - acc2 + 1 != 7) begin
        failures++;
        $display("FAIL b2b_timing got accept=%0d lat=%0d exp accept=%0d lat=7",
                 acc2, dc2 - acc2 + 1, dc1 + 1);
      end
    end
    checks++;
    if (exp_q.size() != 0 || refill_count !== 16'd2 || rerr1 + rerr2 != 0) begin
      failures++;
      $display("FAIL b2b_count got cnt=%0d missing=%0d req_errs=%0d exp cnt=2 missing=0 req_errs=0",
               refill_count, exp_q.size(), rerr1 + rerr2);
    end
  endtask

  task automatic test_spurious();
    int acc, rerr;
    logic [31:0] ra, addr;
    addr = $urandom;
    // mem_resp_valid is high in IDLE, REQ and DONE; only real beats may write.
    do_refill(addr, 2, 0, 1'b1, 1'b0, '0, acc, rerr, ra);
    @(posedge clk); #3;
    model_count = (model_count + 1 > 65535) ? 65535 : model_count + 1;
    checks++;
    if (done_line_q.size() != 1) begin
      failures++;
      $display("FAIL spurious_done_pulses got %0d exp 1", done_line_q.size());
    end else begin
      void'(done_cyc_q.pop_front());
      checks++;
      if (done_line_q.pop_front() !== line_of(addr)) begin
        failures++;
        $display("FAIL spurious_line got other exp %h", line_of(addr));
      end
    end
    checks++;
    if (exp_q.size() != 0 || refill_count !== 16'(model_count) || rerr != 0) begin
      failures++;
      $display("FAIL spurious_count got cnt=%0d missing=%0d req_errs=%0d exp cnt=%0d missing=0 req_errs=0",
               refill_count, exp_q.size(), rerr, model_count);
    end
  endtask

  task automatic test_reset_mid();
    int acc, rerr;
    logic [31:0] ra;
    apply_reset();
    @(posedge clk); #2;
    miss_valid = 1'b1; miss_addr = 32'h0000_0080;
    @(posedge clk); #2;
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
      exp_q.push_back({word_idx(32'h0000_0080, i), mem_resp_data});
    end
    // Remaining beats keep arriving while reset is asserted and just after.
    @(posedge clk); #2;
    rst = 1'b1; mem_resp_data = $urandom;
    @(posedge clk); #2;
    mem_resp_data = $urandom;
    @(posedge clk); #2;
    rst = 1'b0; mem_resp_data = $urandom;
    @(posedge clk); #2;
    mem_resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    model_count = 0;
    checks++;
    if (done_line_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_abandon got done=%0d missing=%0d exp 0 0", done_line_q.size(), exp_q.size());
    end
    checks++;
    if (miss_ready !== 1'b1 || busy !== 1'b0 || refill_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_idle got rdy=%b busy=%b cnt=%0d exp 1 0 0", miss_ready, busy, refill_count);
    end
    done_line_q.delete(); done_cyc_q.delete();
    do_refill(32'h0000_0040, 0, 0, 1'b0, 1'b0, '0, acc, rerr, ra);
    @(posedge clk); #3;
    model_count = 1;
    checks++;
    if (done_line_q.size() != 1 || exp_q.size() != 0 || refill_count !== 16'd1) begin
      failures++;
      $display("FAIL reset_mid_next got done=%0d missing=%0d cnt=%0d exp 1 0 1",
               done_line_q.size(), exp_q.size(), refill_count);
    end
    done_line_q.delete(); done_cyc_q.delete();
  endtask

  task automatic test_random();
    int acc, rerr, dc, stall, gap;
    bit sp;
    logic [31:0] ra, addr, line;
    for (int n = 0; n < 8; n++) begin
      addr  = $urandom;
      stall = $urandom_range(0, 3);
      gap   = $urandom_range(0, 2);
      sp    = 1'($urandom_range(0, 1));
      do_refill(addr, stall, gap, sp, 1'b0, '0, acc, rerr, ra);
      @(posedge clk); #3;
      model_count = (model_count + 1 > 65535) ? 65535 : model_count + 1;
      checks++;
      if (done_line_q.size() != 1) begin
        failures++;
        $display("FAIL random_done_pulses n=%0d got %0d exp 1", n, done_line_q.size());
      end else begin
        line = done_line_q.pop_front();
        dc = done_cyc_q.pop_front();
        checks++;
        if (line !== line_of(addr) || dc - acc + 1 != 3 + stall + NB * (gap + 1)) begin
          failures++;
          $display("FAIL random_line_latency n=%0d got %h/%0d exp %h/%0d", n, line,
                   dc - acc + 1, line_of(addr), 3 + stall + NB * (gap + 1));
        end
      end
      checks++;
      if (exp_q.size() != 0 || refill_count !== 16'(model_count) || rerr != 0) begin
        failures++;
        $display("FAIL random_count n=%0d got cnt=%0d missing=%0d req_errs=%0d exp cnt=%0d missing=0 req_errs=0",
                 n, refill_count, exp_q.size(), rerr, model_count);
      end
    end
  endtask

  task automatic test_saturation();
    int acc, rerr;
    logic [31:0] ra;
    @(posedge clk); #3;
    force dut.refill_count_q = 16'hFFFF;
    #1;
    release dut.refill_count_q;
    model_count = 65535;
    do_refill($urandom, 0, 0, 1'b0, 1'b0, '0, acc, rerr, ra);
    @(posedge clk); #3;
    model_count = (model_count + 1 > 65535) ? 65535 : model_count + 1;
    checks++;
    if (refill_count !== 16'(model_count) || done_line_q.size() != 1) begin
      failures++;
      $display("FAIL saturation got cnt=%h done=%0d exp cnt=%h done=1",
               refill_count, done_line_q.size(), 16'(model_count));
    end
    done_line_q.delete(); done_cyc_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    miss_valid = 1'b0; miss_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_random();
    test_saturation();
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_scoreboard got %0d outstanding writes exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_refill_engine.md
DCACHE_REFILL_ENGINE -- requirements
Module: dcache_refill_engine

Interface
REQ-001 Parameter DWIDTH, default 32, data RAM word width and memory beat width in bits.
REQ-002 Parameter AWIDTH, default 8, data RAM address width in bits.
REQ-003 Parameter WORD_BITS, default 2, log2 of words per cache line; 2^WORD_BITS beats per refill.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 miss_valid  input  1  cache miss request pending.
REQ-007 miss_ready  output  1  engine accepts a miss this cycle.
REQ-008 miss_addr  input  32  byte address of the missing access.
REQ-009 mem_req_valid  output  1  line read request to memory.
REQ-010 mem_req_ready  input  1  memory accepts the request.
REQ-011 mem_req_addr  output  32  line-aligned byte address; low WORD_BITS+2 bits zero.
REQ-012 mem_resp_valid  input  1  one data beat present; no backpressure, beats arrive in word order.
REQ-013 mem_resp_data  input  DWIDTH  beat data.
REQ-014 ram_addr  output  AWIDTH  data RAM write-port address.
REQ-015 ram_d  output  DWIDTH  data RAM write data.
REQ-016 ram_we  output  1  data RAM write enable.
REQ-017 refill_done  output  1  one-cycle pulse: the whole line is written to the RAM.
REQ-018 refill_line  output  32  line-aligned address of the refilled line, valid while refill_done is high.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 refill_count  output  16  number of completed refills; saturates at 0xFFFF.

Function
REQ-021 FSM states: IDLE, REQ, FILL, DONE.
REQ-022 IDLE: miss_ready=1; when miss_valid=1, latch miss_addr with low WORD_BITS+2 bits cleared as line_addr, clear beat_cnt, go to REQ.
REQ-023 REQ: mem_req_valid=1 and mem_req_addr=line_addr, held stable until mem_req_ready=1; that cycle go to FILL.
REQ-024 FILL: when mem_resp_valid=1, in the same cycle drive ram_we=1, ram_d=mem_resp_data and ram_addr={line_addr[AWIDTH+1:WORD_BITS+2], beat_cnt}; increment beat_cnt.
REQ-025 FILL: the beat with beat_cnt=2^WORD_BITS-1 moves the FSM to DONE; beat_cnt wraps to 0.
REQ-026 FILL with mem_resp_valid=0: no write, no count change, no timeout.
REQ-027 DONE lasts exactly one cycle: refill_done=1, refill_line=line_addr, refill_count increments unless already 0xFFFF, then go to IDLE.
REQ-028 ram_we=0 in IDLE, REQ and DONE; mem_resp_valid outside FILL is ignored.
REQ-029 miss_ready=0 outside IDLE; a miss held through DONE is accepted in the following IDLE cycle, giving a minimum of one idle cycle between refills.
REQ-030 Minimum miss-to-refill_done latency: 3 + 2^WORD_BITS cycles, i.e. 7 cycles for WORD_BITS=2 with zero memory stalls.
REQ-031 mem_req_valid, ram_we, miss_ready, busy and refill_done are Moore or state-qualified combinational outputs; there are no combinational paths from miss_valid to any output.

Reset
REQ-032 While rst=1: the FSM is in IDLE, beat_cnt=0, line_addr=0, refill_count=0.
REQ-033 While rst=1, every output is held low, including miss_ready, and ram_we is never asserted.
REQ-034 Reset mid-refill abandons the line: no further RAM writes occur, and no refill_done is issued for it.
REQ-035 After rst falls, the first cycle is IDLE with miss_ready=1.

Verification
REQ-036 Basic refill: miss_addr=0x00001234, mem_req_ready=1, beats 0xA0..0xA3 back-to-back -> mem_req_addr=0x00001230; writes to ram_addr 0x8C..0x8F with 0xA0..0xA3; refill_done 7 cycles after acceptance; refill_line=0x00001230; refill_count=1.
REQ-037 Memory stall: mem_req_ready low for 5 cycles, then one bubble between each beat -> mem_req_valid and mem_req_addr are stable throughout; exactly 4 ram_we pulses; refill_done follows the last beat by 1 cycle.
REQ-038 Back-to-back misses at 0x00000000 and then 0x000003F0 -> the second is accepted in the IDLE cycle after DONE; second line writes ram_addr 0xFC..0xFF; refill_count=2.
REQ-039 Reset after the 2nd beat -> no further ram_we and no refill_done; next miss at 0x00000040 refills ram_addr 0x10..0x13 with refill_count=1.
REQ-040 Spurious mem_resp_valid in IDLE and REQ -> ram_we stays 0 and beat_cnt is unchanged.
REQ-041 Force refill_count=0xFFFF, then complete one refill -> refill_count stays 0xFFFF.
